sdram_init: RTL and testbench

SDRAM_INIT -- requirements
Module: sdram_init

---
 rtl/sdram_init.sv | 157 +++++++++++++++
 tb/tb_sdram_init.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sdram_init.sv
// SDRAM power-up initialization sequencer: power wait, precharge-all, auto refreshes, mode register load.
// Optional macro SDRAM_INIT_FAST_SIM_EN shortens the power-up wait to 100 cycles.
module sdram_init #(
    parameter logic [2:0]  CAS     = 3'b011,
    parameter int unsigned T_POWER = 20000,
    parameter int unsigned T_RP    = 2,
    parameter int unsigned T_RC    = 7,
    parameter int unsigned T_MRD   = 3,
    parameter int unsigned REF_NUM = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_bank_addr,
    output logic [12:0] init_addr,
    output logic        init_end
);

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned T_PWR_EFF = 100;
`else
    localparam int unsigned T_PWR_EFF = T_POWER;
`endif

    localparam int unsigned CNT_W = ($clog2(T_PWR_EFF + 1) > 15) ? $clog2(T_PWR_EFF + 1) : 15;
    localparam int unsigned REF_W = 4;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [3:0]  CMD_LMR  = 4'b0000;

    // Burst write, CAS latency, sequential, full page
    localparam logic [12:0] MODE_VAL = {3'b000, 1'b0, 2'b00, CAS, 1'b0, 3'b111};
    localparam logic [12:0] PRE_ALL  = 13'h0400;

    typedef enum logic [2:0] {
        WAIT_PWR,
        PRE,
        WAIT_RP,
        AREF,
        WAIT_RC,
        MRS,
        WAIT_MRD,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [REF_W-1:0]   ref_cnt, ref_cnt_d;
    logic [3:0]         cmd_d;
    logic [12:0]        addr_d;
    logic               end_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_PWR;
            cnt            <= '0;
            ref_cnt        <= '0;
            init_cmd       <= CMD_NOP;
            init_bank_addr <= 2'b00;
            init_addr      <= '0;
            init_end       <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ref_cnt        <= ref_cnt_d;
            init_cmd       <= cmd_d;
            init_bank_addr <= 2'b00;
            init_addr      <= addr_d;
            init_end       <= end_d;
        end
    end

    // Next state; each state names the command visible in the cycle it is occupied
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ref_cnt_d = ref_cnt;
        unique case (state)
            WAIT_PWR: begin
                if (cnt == CNT_W'(T_PWR_EFF - 1)) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PRE: begin
                state_d = WAIT_RP;
                cnt_d   = '0;
            end
            WAIT_RP: begin
                if (cnt == CNT_W'(T_RP - 1)) begin
                    state_d = AREF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            AREF: begin
                state_d   = WAIT_RC;
                cnt_d     = '0;
                ref_cnt_d = ref_cnt + REF_W'(1);
            end
            WAIT_RC: begin
                if (cnt == CNT_W'(T_RC - 1)) begin
                    state_d = (ref_cnt == REF_W'(REF_NUM)) ? MRS : AREF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            MRS: begin
                state_d = WAIT_MRD;
                cnt_d   = '0;
            end
            WAIT_MRD: begin
                if (cnt == CNT_W'(T_MRD - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_PWR;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values that get registered alongside the next state
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        end_d  = 1'b0;
        unique case (state_d)
            PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = PRE_ALL;
            end
            AREF: cmd_d = CMD_AREF;
            MRS: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_VAL;
            end
            DONE:    end_d = 1'b1;
            default: cmd_d = CMD_NOP;
        endcase
    end

endmodule

// File: tb/tb_sdram_init.sv
// Randomized reset-pulse bench for sdram_init, checked every cycle against a cycle-number
// schedule model of the init sequence, plus literal pins on key cycles.
module tb_sdram_init;

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int P = 100;
`else
    localparam int P = 20000;
`endif
    localparam int TRP = 2;
    localparam int TRC = 7;
    localparam int TMRD = 3;
    localparam int NREF = 8;
    localparam int BASE = P + 1 + TRP;
    localparam int MODE_CYC = BASE + NREF * (TRC + 1);
    localparam int END_CYC = MODE_CYC + TMRD + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank_addr;
    logic [12:0] init_addr;
    logic        init_end;

    int total = 0;
    int bad = 0;
    int n = 0;
    int aref_seen = 0;
    int load_seen = 0;
    logic r_s;
    logic [3:0]  e_cmd;
    logic [12:0] e_addr;
    logic        e_end;

    sdram_init dut (
        .clk(clk),
        .reset(reset),
        .init_cmd(init_cmd),
        .init_bank_addr(init_bank_addr),
        .init_addr(init_addr),
        .init_end(init_end)
    );

    always #5 clk = ~clk;

    // Expected outputs from the schedule: cycle number since reset release
    task automatic model(input int c, output logic [3:0] cmd, output logic [12:0] addr,
                         output logic fin);
        cmd = 4'b0111;
        addr = 13'h0000;
        fin = 1'b0;
        if (c == P) begin
            cmd = 4'b0010;
            addr = 13'h0400;
        end else if (c >= BASE && c < MODE_CYC) begin
            if ((c - BASE) % (TRC + 1) == 0) cmd = 4'b0001;
        end else if (c == MODE_CYC) begin
            cmd = 4'b0000;
            addr = {3'b000, 1'b0, 2'b00, 3'b011, 1'b0, 3'b111};
        end else if (c >= END_CYC) begin
            fin = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        r_s = reset;
        if (r_s) begin
            n = 0;
            aref_seen = 0;
            load_seen = 0;
        end else begin
            n++;
        end
        #1;
        if (r_s) begin
            chk("rst_cmd", init_cmd, 4'b0111);
            chk("rst_addr", init_addr, 0);
            chk("rst_end", init_end, 0);
        end else begin
            model(n, e_cmd, e_addr, e_end);
            chk("cmd", init_cmd, e_cmd);
            chk("addr", init_addr, e_addr);
            chk("end", init_end, e_end);
            if (init_cmd == 4'b0001) aref_seen++;
            if (init_cmd == 4'b0000) load_seen++;
            if (n == P) begin
                chk("pin_pre_cmd", init_cmd, 4'b0010);
                chk("pin_pre_addr", init_addr, 13'h0400);
            end
            if (n == P + 3) chk("pin_aref0", init_cmd, 4'b0001);
            if (n == P + 59) chk("pin_aref7", init_cmd, 4'b0001);
            if (n == P + 67) begin
                chk("pin_lmr_cmd", init_cmd, 4'b0000);
                chk("pin_lmr_addr", init_addr, 13'h0037);
            end
            if (n == P + 70) chk("pin_end_lo", init_end, 0);
            if (n == P + 71) begin
                chk("pin_end_hi", init_end, 1);
                chk("aref_count", aref_seen, 8);
                chk("load_count", load_seen, 1);
            end
        end
        chk("bank", init_bank_addr, 0);
    end

    task automatic run(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int len);
        reset = 1'b1;
        repeat (len) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(P + 80);
        pulse(1);
        run(P + 30);
        pulse(1);
        run(P + 80);
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(1, P / 4 + 75));
            pulse($urandom_range(1, 3));
        end
        run(P / 4 + 80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
